// File: rtl/buffer_mp.sv
// Multi-read-port scratch buffer: one write port, NUM_RD registered read ports,
// optional read-after-write bypass and a sequential clear sweep.
module buffer_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    clr_state_t          state_r;
    clr_state_t          state_s;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     cnt_s;
    logic                busy_s;
    logic                done_s;
    logic                wr_accept_s;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_addr_s [NUM_RD];
    logic [DATA_W-1:0]   rd_word_s [NUM_RD];
    logic [DATA_W-1:0]   rd_q_r    [NUM_RD];
    logic [NUM_RD-1:0]   rd_v_r;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        assign rd_addr_s[g]                  = rd_addr[g*ADDR_W +: ADDR_W];
        assign rd_data[g*DATA_W +: DATA_W]   = rd_q_r[g];
    end
    assign rd_valid = rd_v_r;

    // Host writes are refused while the sweep owns the array or when out of range.
    always_comb begin
        wr_accept_s = wr_en && !clr_busy && ({1'b0, wr_addr} < DEPTH_L);
    end

    // Clear FSM state, sweep counter and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            clr_busy <= busy_s;
            clr_done <= done_s;
        end
    end

    // Clear FSM next state; the counter is one bit wider so DEPTH = 2^ADDR_W cannot wrap.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    state_s = CLEAR;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                busy_s = 1'b1;
                cnt_s  = cnt_r + 1'b1;
                if (cnt_r == LAST_L) begin
                    state_s = DONE;
                end else begin
                    state_s = CLEAR;
                end
            end
            DONE: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Storage array; contents are deliberately not reset, the sweep write wins a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        if (state_r == CLEAR) begin
            mem[cnt_r[IDX_W-1:0]] <= '0;
        end
    end

    // Per-port read word selection: zero when clearing or out of range, else bypass or array.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_word_s[i] = '0;
            if (clr_busy || ({1'b0, rd_addr_s[i]} >= DEPTH_L)) begin
                rd_word_s[i] = '0;
            end else if ((BYPASS != 0) && wr_accept_s && (wr_addr == rd_addr_s[i])) begin
                rd_word_s[i] = wr_data;
            end else begin
                rd_word_s[i] = mem[rd_addr_s[i][IDX_W-1:0]];
            end
        end
    end

    // Read port registers; data holds when a port is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_q_r[i] <= '0;
            end
            rd_v_r <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_q_r[i] <= rd_word_s[i];
                    rd_v_r[i] <= 1'b1;
                end else begin
                    rd_v_r[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_buffer_mp.sv
// Directed bench for buffer_mp: a 4-port bypassing 256-word instance and a
// 2-port non-bypassing 200-word instance.
module tb_buffer_mp;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         a_wr_en = 1'b0;
    logic [7:0]   a_wr_addr = 8'd0;
    logic [31:0]  a_wr_data = 32'd0;
    logic [3:0]   a_rd_en = 4'd0;
    logic [31:0]  a_rd_addr = 32'd0;
    logic [127:0] a_rd_data;
    logic [3:0]   a_rd_valid;
    logic         a_clr_start = 1'b0;
    logic         a_clr_busy;
    logic         a_clr_done;

    logic         b_wr_en = 1'b0;
    logic [7:0]   b_wr_addr = 8'd0;
    logic [31:0]  b_wr_data = 32'd0;
    logic [1:0]   b_rd_en = 2'd0;
    logic [15:0]  b_rd_addr = 16'd0;
    logic [63:0]  b_rd_data;
    logic [1:0]   b_rd_valid;
    logic         b_clr_start = 1'b0;
    logic         b_clr_busy;
    logic         b_clr_done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    buffer_mp #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .NUM_RD(4), .BYPASS(1)) u_a (
        .clk(clk), .reset(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .clr_start(a_clr_start), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
    );

    buffer_mp #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .NUM_RD(2), .BYPASS(0)) u_b (
        .clk(clk), .reset(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .clr_start(b_clr_start), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_fill();
        for (int i = 0; i < 256; i++) begin
            a_wr_en   = 1'b1;
            a_wr_addr = 8'(i);
            a_wr_data = 32'(i + 1);
            tick();
        end
        a_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #2;
        tests_run++;
        if (a_rd_data !== 128'd0) begin tests_failed++; $display("FAIL reset_a_rd_data: got %h want 0", a_rd_data); end
        tests_run++;
        if (a_rd_valid !== 4'd0) begin tests_failed++; $display("FAIL reset_a_rd_valid: got %b want 0000", a_rd_valid); end
        tests_run++;
        if ({a_clr_busy, a_clr_done, b_clr_busy, b_clr_done} !== 4'd0) begin
            tests_failed++; $display("FAIL reset_clr_flags: got %b want 0000", {a_clr_busy, a_clr_done, b_clr_busy, b_clr_done});
        end
        tests_run++;
        if ({b_rd_data, b_rd_valid} !== 66'd0) begin tests_failed++; $display("FAIL reset_b_outputs: got %h want 0", {b_rd_data, b_rd_valid}); end
        #8;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        a_wr_en = 1'b1; a_wr_addr = 8'd0; a_wr_data = 32'd1; tick();
        a_wr_addr = 8'd1; tick();
        a_wr_addr = 8'd2; a_wr_data = 32'hA5A5_0001; tick();
        a_wr_addr = 8'd3; a_wr_data = 32'h1234_5678; tick();
        a_wr_en = 1'b0;
        a_rd_en = 4'b1111;
        a_rd_addr = {8'd2, 8'd3, 8'd1, 8'd0};
        tick();
        tests_run++;
        if (a_rd_data[63:0] !== {32'd1, 32'd1}) begin tests_failed++; $display("FAIL basic_p01: got %h want 0000000100000001", a_rd_data[63:0]); end
        tests_run++;
        if (a_rd_data[127:64] !== {32'hA5A5_0001, 32'h1234_5678}) begin
            tests_failed++; $display("FAIL basic_p23: got %h want a5a5000112345678", a_rd_data[127:64]);
        end
        tests_run++;
        if (a_rd_valid !== 4'b1111) begin tests_failed++; $display("FAIL basic_valid: got %b want 1111", a_rd_valid); end
        a_rd_en = 4'b0000;
        a_rd_addr = 32'd0;
        tick();
        tests_run++;
        if (a_rd_valid !== 4'b0000) begin tests_failed++; $display("FAIL basic_idle_valid: got %b want 0000", a_rd_valid); end
        tests_run++;
        if (a_rd_data !== {32'hA5A5_0001, 32'h1234_5678, 32'd1, 32'd1}) begin
            tests_failed++; $display("FAIL basic_hold: got %h", a_rd_data);
        end
    endtask

    task automatic test_bypass();
        a_wr_en = 1'b1; a_wr_addr = 8'd5; a_wr_data = 32'h11; tick();
        a_wr_data = 32'hDEAD_BEEF;
        a_rd_en = 4'b0100; a_rd_addr = {8'd0, 8'd5, 8'd0, 8'd0};
        tick();
        a_wr_en = 1'b0; a_rd_en = 4'b0000;
        tests_run++;
        if (a_rd_data[95:64] !== 32'hDEAD_BEEF || a_rd_valid !== 4'b0100) begin
            tests_failed++; $display("FAIL bypass_on: got %h/%b want deadbeef/0100", a_rd_data[95:64], a_rd_valid);
        end
        b_wr_en = 1'b1; b_wr_addr = 8'd5; b_wr_data = 32'h11; tick();
        b_wr_data = 32'hDEAD_BEEF;
        b_rd_en = 2'b01; b_rd_addr = {8'd0, 8'd5};
        tick();
        b_wr_en = 1'b0;
        tests_run++;
        if (b_rd_data[31:0] !== 32'h11) begin tests_failed++; $display("FAIL bypass_off_old: got %h want 00000011", b_rd_data[31:0]); end
        tick();
        b_rd_en = 2'b00;
        tests_run++;
        if (b_rd_data[31:0] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL bypass_off_new: got %h want deadbeef", b_rd_data[31:0]); end
    endtask

    task automatic test_range();
        b_wr_en = 1'b1; b_wr_addr = 8'd250; b_wr_data = 32'd7; tick();
        b_wr_addr = 8'd199; b_wr_data = 32'd9; tick();
        b_wr_en = 1'b0;
        b_rd_en = 2'b11; b_rd_addr = {8'd200, 8'd250};
        tick();
        tests_run++;
        if (b_rd_data !== 64'd0 || b_rd_valid !== 2'b11) begin
            tests_failed++; $display("FAIL range_oob: got %h/%b want 0/11", b_rd_data, b_rd_valid);
        end
        b_rd_addr = {8'd0, 8'd199};
        b_rd_en = 2'b01;
        tick();
        b_rd_en = 2'b00;
        tests_run++;
        if (b_rd_data[31:0] !== 32'd9) begin tests_failed++; $display("FAIL range_last: got %h want 9", b_rd_data[31:0]); end
        a_wr_en = 1'b1; a_wr_addr = 8'd255; a_wr_data = 32'hFF00_FF00; tick();
        a_wr_en = 1'b0;
        a_rd_en = 4'b0001; a_rd_addr = {8'd0, 8'd0, 8'd0, 8'd255};
        tick();
        a_rd_en = 4'b0000;
        tests_run++;
        if (a_rd_data[31:0] !== 32'hFF00_FF00) begin tests_failed++; $display("FAIL range_full_depth: got %h want ff00ff00", a_rd_data[31:0]); end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        int first_busy = -1;
        int done_k = -1;
        int bad = 0;
        logic [31:0] exp;
        a_fill();
        a_clr_start = 1'b1;
        tick();
        a_clr_start = 1'b0;
        tests_run++;
        if (a_clr_busy !== 1'b0) begin tests_failed++; $display("FAIL clear_busy_latency: got %b want 0", a_clr_busy); end
        for (int k = 1; k <= 270; k++) begin
            tick();
            a_wr_en = 1'b0;
            if (a_clr_busy === 1'b1) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = k;
            end
            if (a_clr_done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (k == 50) begin a_rd_en = 4'b0001; a_rd_addr = {8'd0, 8'd0, 8'd0, 8'd200}; end
            if (k == 51) begin
                a_rd_en = 4'b0000;
                tests_run++;
                if (a_rd_data[31:0] !== 32'd0 || a_rd_valid[0] !== 1'b1) begin
                    tests_failed++; $display("FAIL clear_read_busy: got %h/%b want 0/1", a_rd_data[31:0], a_rd_valid[0]);
                end
            end
            if (k == 100) begin a_wr_en = 1'b1; a_wr_addr = 8'd3; a_wr_data = 32'h77; end
            if (k == 257) begin a_wr_en = 1'b1; a_wr_addr = 8'd7; a_wr_data = 32'h5A; end
        end
        tests_run++;
        if (busy_cnt != 256 || first_busy != 1) begin
            tests_failed++; $display("FAIL clear_busy_window: got %0d cycles from %0d want 256 from 1", busy_cnt, first_busy);
        end
        tests_run++;
        if (done_cnt != 1 || done_k != 257) begin
            tests_failed++; $display("FAIL clear_done_pulse: got %0d pulses at %0d want 1 at 257", done_cnt, done_k);
        end
        for (int j = 0; j < 64; j++) begin
            a_rd_en = 4'b1111;
            a_rd_addr = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            tick();
            for (int p = 0; p < 4; p++) begin
                exp = ((4*j + p) == 7) ? 32'h5A : 32'd0;
                if (a_rd_data[p*32 +: 32] !== exp) begin
                    if (bad == 0) $display("  first bad addr %0d: %h", 4*j + p, a_rd_data[p*32 +: 32]);
                    bad++;
                end
            end
        end
        a_rd_en = 4'b0000;
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL clear_contents: got %0d bad words want 0", bad); end
    endtask

    task automatic test_reset_midclear();
        int busy_cnt = 0;
        int done_cnt = 0;
        int bad = 0;
        a_fill();
        a_clr_start = 1'b1;
        tick();
        a_clr_start = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        #2;
        tests_run++;
        if ({a_clr_busy, a_clr_done, a_rd_valid} !== 6'd0) begin
            tests_failed++; $display("FAIL midclear_reset_flags: got %b want 000000", {a_clr_busy, a_clr_done, a_rd_valid});
        end
        #8;
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (a_clr_busy !== 1'b0) busy_cnt++;
            if (a_clr_done !== 1'b0) done_cnt++;
        end
        tests_run++;
        if (busy_cnt != 0 || done_cnt != 0) begin
            tests_failed++; $display("FAIL midclear_no_done: got busy %0d done %0d want 0 0", busy_cnt, done_cnt);
        end
        for (int j = 0; j < 25; j++) begin
            a_rd_en = 4'b1111;
            a_rd_addr = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
            tick();
            if (a_rd_data !== 128'd0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL midclear_swept: got %0d bad groups want 0", bad); end
        a_rd_addr = {4{8'd150}};
        tick();
        tests_run++;
        if (a_rd_data !== {4{32'd151}} || a_rd_valid !== 4'b1111) begin
            tests_failed++; $display("FAIL midclear_multiport: got %h/%b want 4x151/1111", a_rd_data, a_rd_valid);
        end
        a_rd_en = 4'b0001;
        a_rd_addr = {8'd0, 8'd0, 8'd0, 8'd100};
        tick();
        a_rd_en = 4'b0000;
        tests_run++;
        if (a_rd_data[31:0] !== 32'd101) begin tests_failed++; $display("FAIL midclear_unswept: got %h want 101", a_rd_data[31:0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_range();
        test_clear();
        test_reset_midclear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/buffer_mp.md
# buffer_mp

Parametrised successor to the two-read-port scratch buffer used by the PE datapath. It holds `DEPTH` words of `DATA_W` bits, with one write port and `NUM_RD` independent registered read ports, each carrying a per-port read valid. It adds optional same-cycle read-after-write bypass and a sequential clear engine that zeroes the whole array without a reset. The block sits between the PE's namespace interconnect and the ALU operand muxes, replacing the fixed 256x32, 2-read buffer.

## Interface
- `DATA_W`, 32, word width in bits.
- `ADDR_W`, 8, address width in bits.
- `DEPTH`, 256, number of words; must satisfy 1 <= `DEPTH` <= 2^`ADDR_W`.
- `NUM_RD`, 2, number of read ports; must be >= 1.
- `BYPASS`, 1, enables read-after-write forwarding when 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  `ADDR_W`  write address.
- `wr_data`  in  `DATA_W`  write data.
- `rd_en`  in  `NUM_RD`  per-port read strobe.
- `rd_addr`  in  `NUM_RD*ADDR_W`  flattened read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- `rd_data`  out  `NUM_RD*DATA_W`  flattened registered read data; port i uses bits [i*DATA_W +: DATA_W].
- `rd_valid`  out  `NUM_RD`  per-port flag, high for exactly one cycle after an accepted read.
- `clr_start`  in  1  request to zero the entire array.
- `clr_busy`  out  1  high while the clear sweep runs.
- `clr_done`  out  1  one-cycle pulse when the sweep completes.

## Operation
- **Write:** at a rising edge with `wr_en`=1, `clr_busy`=0 and `wr_addr` < `DEPTH`, the block stores `mem[wr_addr]` <= `wr_data`.
  - A write with `wr_addr` >= `DEPTH` is silently dropped.
  - A write while `clr_busy`=1 is silently dropped.
- **Read, port i:** at a rising edge with `rd_en[i]`=1, the port loads its `rd_data` slice and sets `rd_valid[i]`=1 for one cycle.
  - With `rd_en[i]`=0, `rd_valid[i]`=0 and the `rd_data` slice holds its previous value.
  - An address >= `DEPTH` returns 0, with valid asserted.
  - A read while `clr_busy`=1 returns 0, with valid asserted.
- **Bypass (`BYPASS`=1):** when an accepted write and a read on port i target the same in-range address at the same edge, port i returns `wr_data`. With `BYPASS`=0 it returns the pre-write contents.
- **All ports are independent.** Any number of ports may read the same address in the same cycle.
- **Clear FSM**, states IDLE, CLEAR, DONE:
  - IDLE: `clr_start`=1 moves to CLEAR and sets the counter to 0.
  - CLEAR: each cycle writes `mem[cnt]` <= 0 and increments `cnt`. At `cnt` = `DEPTH`-1 it writes the last word and moves to DONE.
  - DONE: asserts `clr_done` for one cycle, then returns to IDLE.
  - `clr_busy` is high exactly in CLEAR.
  - `clr_start` is ignored in CLEAR and DONE.
- **Counter width:** `ADDR_W`+1 bits, so `DEPTH` = 2^`ADDR_W` terminates without wrap.
- **Reset:** `reset` does not initialise memory contents. Software must run a clear sweep before relying on contents.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `clr_busy`=0, `clr_done`=0, FSM=IDLE, counter=0. They take effect immediately on assertion, independent of `clk`.
- Read latency is 1 cycle:
  - `rd_en`/`rd_addr` sampled at edge N produce `rd_data` and `rd_valid` after edge N, held through edge N+1.
- Write-to-read:
  - A write at edge N is visible to a read sampled at edge N+1.
  - With `BYPASS`=1 it is also visible to a read sampled at edge N.
- Clear timing for `clr_start` sampled at edge N:
  - `clr_busy`=1 from after edge N+1 through after edge N+`DEPTH`.
  - `clr_done`=1 in the following cycle.
  - Total sweep time is `DEPTH` cycles of busy.
- The first write accepted after a clear is at the edge where `clr_done`=1.
- Reset asserted mid-clear returns the FSM to IDLE immediately.
  - Words already swept stay 0; the remainder keep their old values.
  - `clr_done` is not pulsed.
- `rd_valid` is asserted for every accepted read, including out-of-range reads and reads during clear.

## Test plan
- **Reset:** pulse `reset` for 10 ns mid-cycle -> all outputs 0 within the reset pulse, before the next `clk` edge; `clr_busy`=0.
- **Basic write/read:** write `mem[0]`=1 and `mem[1]`=1 on consecutive edges; read port0 addr 0 and port1 addr 1 -> both `rd_data` slices = 1 and `rd_valid`=2'b11 one cycle later. The next cycle with `rd_en`=0 -> `rd_valid`=0 and data held.
- **Bypass:** `BYPASS`=1; write `mem[5]`=0xDEADBEEF and read addr 5 at the same edge -> 0xDEADBEEF next cycle. Rerun with `BYPASS`=0, old value 0x11 -> 0x11, then a subsequent read returns 0xDEADBEEF.
- **Range:** `DEPTH`=200; write addr 250 = 7 -> dropped. Read addr 250 -> 0 with valid. Read addr 199 after writing 9 -> 9.
- **Clear:** fill addrs 0..255 with addr+1; pulse `clr_start` -> `clr_busy` high for 256 cycles, `clr_done` pulses once. A write attempted during busy is dropped. Reads of every address after done -> 0.
- **Reset mid-clear and multi-port:** `NUM_RD`=4; start a clear, assert `reset` at `cnt`=100 -> `clr_busy`=0 and no `clr_done` pulse. Addrs 0..99 read 0; addr 150 reads its old value 151 on all 4 ports simultaneously.
